bhr_checkpoint_unit: RTL and testbench

Speculative global branch-history manager directly upstream of the correlating predictor's pattern history table. Shifts each predicted direction into a speculative history register that drives the predictor's history input. Holds an in-order checkpoint FIFO of in-flight branches. At resolution it emits a training record carrying the history and index used at prediction time, and on a misprediction it repairs the speculative history from the committed history.

---
 rtl/bp_pkg.sv | 19 +
 rtl/bhr_ckpt_fifo.sv | 51 +++++
 rtl/bhr_checkpoint_unit.sv | 107 ++++++++++
 tb/tb_bhr_checkpoint_unit.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bp_pkg.sv
// Shared branch-predictor types: checkpoint record and the history shift helper.
// Default history/index widths live here so producer and FIFO agree on the layout.
package bp_pkg;

    localparam int BP_M = 4;
    localparam int BP_K = 4;

    typedef struct packed {
        logic [BP_K-1:0] index;
        logic [BP_M-1:0] bhr;
        logic            taken;
    } bp_ckpt_t;

    function automatic logic [BP_M-1:0] bhr_shift(input logic [BP_M-1:0] hist,
                                                  input logic            dir);
        return {hist[BP_M-2:0], dir};
    endfunction

endpackage

// File: rtl/bhr_ckpt_fifo.sv
// In-order checkpoint FIFO for in-flight branches with push, pop and whole-queue flush.
// Occupancy is kept in an explicit counter so full and empty never rely on pointer equality.
module bhr_ckpt_fifo
    import bp_pkg::*;
#(
    parameter  int DEPTH = 8,
    localparam int CW    = $clog2(DEPTH) + 1,
    localparam int PW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  bp_ckpt_t      push_data,
    input  logic          pop,
    input  logic          flush,
    output logic [CW-1:0] count,
    output bp_ckpt_t      head
);

    bp_ckpt_t        mem [DEPTH];
    logic   [PW-1:0] wr_ptr;
    logic   [PW-1:0] rd_ptr;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push && !flush) mem[wr_ptr] <= push_data;
    end

    assign head = mem[rd_ptr];

endmodule

// File: rtl/bhr_checkpoint_unit.sv
// Speculative global history manager: checkpoints each prediction, trains at resolve, repairs on mispredict.
// Optional feature macro BHR_STATS_EN adds saturating resolve/mispredict counters.
module bhr_checkpoint_unit
    import bp_pkg::*;
#(
    parameter  int M     = BP_M,
    parameter  int K     = BP_K,
    parameter  int DEPTH = 8,
    localparam int CW    = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          pred_valid,
    output logic          pred_ready,
    input  logic [K-1:0]  pred_index,
    input  logic          pred_taken,
    output logic [M-1:0]  spec_bhr,
    input  logic          resolve_valid,
    input  logic          resolve_taken,
    output logic          upd_valid,
    output logic [K-1:0]  upd_index,
    output logic [M-1:0]  upd_bhr,
    output logic          upd_taken,
    output logic          mispredict,
    output logic [CW-1:0] count
`ifdef BHR_STATS_EN
    ,
    output logic [15:0]   stat_resolved,
    output logic [15:0]   stat_mispred
`endif
);

    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [M-1:0] arch_bhr;
    logic         accept;
    logic         resolve;
    logic         mis;
    bp_ckpt_t     head;
    bp_ckpt_t     push_data;

    assign pred_ready = (count != FULL);
    assign accept     = pred_valid & pred_ready;
    assign resolve    = resolve_valid & (count != '0);
    assign mis        = resolve & (head.taken != resolve_taken);

    always_comb begin
        push_data       = '0;
        push_data.index = pred_index;
        push_data.bhr   = spec_bhr;
        push_data.taken = pred_taken;
    end

    // A mispredicting resolve flushes the queue, so a same-cycle accept is wrong-path and dropped.
    bhr_ckpt_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (accept & ~mis),
        .push_data (push_data),
        .pop       (resolve & ~mis),
        .flush     (mis),
        .count     (count),
        .head      (head)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            spec_bhr <= '0;
            arch_bhr <= '0;
        end else begin
            if (resolve) arch_bhr <= bhr_shift(arch_bhr, resolve_taken);
            if (mis)
                spec_bhr <= bhr_shift(arch_bhr, resolve_taken);
            else if (accept)
                spec_bhr <= bhr_shift(spec_bhr, pred_taken);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            upd_valid  <= 1'b0;
            upd_index  <= '0;
            upd_bhr    <= '0;
            upd_taken  <= 1'b0;
            mispredict <= 1'b0;
        end else begin
            upd_valid  <= resolve;
            upd_index  <= resolve ? head.index : '0;
            upd_bhr    <= resolve ? head.bhr : '0;
            upd_taken  <= resolve ? resolve_taken : 1'b0;
            mispredict <= mis;
        end
    end

`ifdef BHR_STATS_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stat_resolved <= '0;
            stat_mispred  <= '0;
        end else begin
            if (resolve && stat_resolved != 16'hFFFF) stat_resolved <= stat_resolved + 16'd1;
            if (mis && stat_mispred != 16'hFFFF)      stat_mispred  <= stat_mispred + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_bhr_checkpoint_unit.sv
// Self-checking bench for bhr_checkpoint_unit against a queue-based reference model.
// Stat counter checks are compiled in when BHR_STATS_EN is defined.
module tb_bhr_checkpoint_unit;

    localparam int DEPTH = 8;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       pred_valid = 1'b0;
    logic       pred_ready;
    logic [3:0] pred_index = '0;
    logic       pred_taken = 1'b0;
    logic [3:0] spec_bhr;
    logic       resolve_valid = 1'b0;
    logic       resolve_taken = 1'b0;
    logic       upd_valid;
    logic [3:0] upd_index;
    logic [3:0] upd_bhr;
    logic       upd_taken;
    logic       mispredict;
    logic [3:0] count;
`ifdef BHR_STATS_EN
    logic [15:0] stat_resolved;
    logic [15:0] stat_mispred;
`endif

    bhr_checkpoint_unit #(.M(4), .K(4), .DEPTH(DEPTH)) dut (
        .clk           (clk),
        .reset         (reset),
        .pred_valid    (pred_valid),
        .pred_ready    (pred_ready),
        .pred_index    (pred_index),
        .pred_taken    (pred_taken),
        .spec_bhr      (spec_bhr),
        .resolve_valid (resolve_valid),
        .resolve_taken (resolve_taken),
        .upd_valid     (upd_valid),
        .upd_index     (upd_index),
        .upd_bhr       (upd_bhr),
        .upd_taken     (upd_taken),
        .mispredict    (mispredict),
        .count         (count)
`ifdef BHR_STATS_EN
        ,
        .stat_resolved (stat_resolved),
        .stat_mispred  (stat_mispred)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        int idx;
        int bhr;
        bit taken;
    } ent_t;

    ent_t q[$];
    int   m_spec, m_arch, m_ui, m_ub, m_res, m_mis_cnt;
    bit   m_uv, m_ut, m_mis;
    bit   obs_ready_pre, exp_ready_pre;
    int   checks = 0;
    int   failures = 0;

    function automatic logic [19:0] observed();
        return {spec_bhr, count, upd_valid, upd_index, upd_bhr, upd_taken, mispredict, pred_ready};
    endfunction

    function automatic logic [19:0] expected();
        logic [3:0] c;
        c = 4'(q.size());
        return {4'(m_spec), c, m_uv, 4'(m_ui), 4'(m_ub), m_ut, m_mis, (q.size() != DEPTH)};
    endfunction

    task automatic model_clear();
        q.delete();
        m_spec = 0; m_arch = 0; m_ui = 0; m_ub = 0; m_res = 0; m_mis_cnt = 0;
        m_uv = 0; m_ut = 0; m_mis = 0;
    endtask

    // Drives one cycle of stimulus and advances the model by the architectural rules.
    task automatic step(input bit pv, input int pi, input bit pt, input bit rv, input bit rt);
        bit acc, res, mis;
        int old_spec;
        ent_t h;
        @(negedge clk);
        pred_valid = pv; pred_index = 4'(pi); pred_taken = pt;
        resolve_valid = rv; resolve_taken = rt;
        #1;
        obs_ready_pre = pred_ready;
        exp_ready_pre = (q.size() != DEPTH);
        @(posedge clk);
        acc = pv && (q.size() != DEPTH);
        res = rv && (q.size() != 0);
        mis = 0;
        old_spec = m_spec;
        m_uv = res; m_ui = 0; m_ub = 0; m_ut = 0;
        if (res) begin
            h = q[0];
            mis = (h.taken != rt);
            m_ui = h.idx; m_ub = h.bhr; m_ut = rt;
            m_arch = (m_arch * 2 + int'(rt)) % 16;
            if (m_res < 65535) m_res++;
            if (mis && m_mis_cnt < 65535) m_mis_cnt++;
        end
        if (mis) begin
            q.delete();
            m_spec = m_arch;
        end else begin
            if (res) void'(q.pop_front());
            if (acc) begin
                q.push_back('{pi, old_spec, pt});
                m_spec = (old_spec * 2 + int'(pt)) % 16;
            end
        end
        m_mis = mis;
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        pred_valid = 1'b0; resolve_valid = 1'b0;
        model_clear();
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        step(1, 3, 1, 0, 0);
        step(1, 4, 0, 0, 0);
        @(negedge clk);
        pred_valid = 1'b1; resolve_valid = 1'b1; resolve_taken = 1'b1;
        reset = 1'b1;
        model_clear();
        #1;
        checks++;
        if (observed() !== expected()) begin
            failures++;
            $display("[TB] FAIL reset_async: got %h expected %h", observed(), expected());
        end
        @(posedge clk); #1;
        checks++;
        if (upd_valid !== 1'b0 || count !== 4'd0 || spec_bhr !== 4'd0) begin
            failures++;
            $display("[TB] FAIL reset_hold: got uv=%b cnt=%0d bhr=%b expected 0 0 0000", upd_valid, count, spec_bhr);
        end
        @(negedge clk);
        pred_valid = 1'b0; resolve_valid = 1'b0;
        reset = 1'b0;
    endtask

    task automatic test_basic();
        int idx[3]     = '{3, 5, 7};
        bit dir[3]     = '{1, 1, 0};
        int spec_x[3]  = '{1, 3, 6};
        int bhr_x[3]   = '{0, 1, 3};
        do_reset();
        for (int i = 0; i < 3; i++) begin
            step(1, idx[i], dir[i], 0, 0);
            checks++;
            if (spec_bhr !== 4'(spec_x[i]) || observed() !== expected()) begin
                failures++;
                $display("[TB] FAIL accept_%0d: got %h expected %h (spec %0d)", i, observed(), expected(), spec_x[i]);
            end
        end
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 0, 1, dir[i]);
            checks++;
            if (upd_valid !== 1'b1 || upd_bhr !== 4'(bhr_x[i]) || upd_index !== 4'(idx[i]) ||
                mispredict !== 1'b0 || observed() !== expected()) begin
                failures++;
                $display("[TB] FAIL resolve_%0d: got %h expected %h", i, observed(), expected());
            end
        end
        checks++;
        if (count !== 4'd0) begin
            failures++;
            $display("[TB] FAIL drained_count: got %0d expected 0", count);
        end
        // A mispredict now exposes the committed history 0110 through the repair value.
        step(1, 1, 1, 0, 0);
        step(0, 0, 0, 1, 0);
        checks++;
        if (spec_bhr !== 4'b1100 || mispredict !== 1'b1) begin
            failures++;
            $display("[TB] FAIL arch_repair: got bhr=%b mis=%b expected 1100 1", spec_bhr, mispredict);
        end
        step(0, 0, 0, 0, 0);
        checks++;
        if (mispredict !== 1'b0 || upd_valid !== 1'b0) begin
            failures++;
            $display("[TB] FAIL pulse_width: got mis=%b uv=%b expected 0 0", mispredict, upd_valid);
        end
    endtask

    task automatic test_mispredict();
        do_reset();
        step(1, 2, 1, 0, 0);
        step(1, 9, 1, 0, 0);
        checks++;
        if (spec_bhr !== 4'b0011) begin
            failures++;
            $display("[TB] FAIL mis_setup: got %b expected 0011", spec_bhr);
        end
        step(0, 0, 0, 1, 0);
        checks++;
        if (mispredict !== 1'b1 || count !== 4'd0 || spec_bhr !== 4'b0000 ||
            upd_index !== 4'd2 || upd_taken !== 1'b0 || observed() !== expected()) begin
            failures++;
            $display("[TB] FAIL mis_flush: got %h expected %h", observed(), expected());
        end
        step(0, 0, 0, 1, 1);
        checks++;
        if (upd_valid !== 1'b0 || observed() !== expected()) begin
            failures++;
            $display("[TB] FAIL resolve_empty: got %h expected %h", observed(), expected());
        end
    endtask

    task automatic test_full();
        do_reset();
        for (int i = 0; i < DEPTH; i++) step(1, i, i % 2, 0, 0);
        checks++;
        if (pred_ready !== 1'b0 || count !== 4'd8) begin
            failures++;
            $display("[TB] FAIL full_ready: got rdy=%b cnt=%0d expected 0 8", pred_ready, count);
        end
        step(1, 15, 1, 0, 0);
        checks++;
        if (count !== 4'd8 || observed() !== expected()) begin
            failures++;
            $display("[TB] FAIL full_reject: got %h expected %h", observed(), expected());
        end
        step(1, 14, 1, 1, q[0].taken);
        checks++;
        if (obs_ready_pre !== 1'b0 || count !== 4'd7 || observed() !== expected()) begin
            failures++;
            $display("[TB] FAIL full_no_bypass: got rdy=%b %h expected rdy=0 %h", obs_ready_pre, observed(), expected());
        end
    endtask

    task automatic test_accept_mispredict();
        do_reset();
        step(1, 1, 1, 0, 0);
        step(1, 2, 0, 0, 0);
        step(1, 6, 1, 1, 0);
        checks++;
        if (count !== 4'd0 || mispredict !== 1'b1 || spec_bhr !== 4'b0000 || observed() !== expected()) begin
            failures++;
            $display("[TB] FAIL accept_mis: got %h expected %h", observed(), expected());
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        step(1, 4, 1, 0, 0);
        step(1, 8, 0, 1, 1);
        checks++;
        if (count !== 4'd1 || spec_bhr !== 4'b0010 || observed() !== expected()) begin
            failures++;
            $display("[TB] FAIL push_pop: got %h expected %h", observed(), expected());
        end
    endtask

    task automatic test_random();
        bit pv, pt, rv, rt;
        int pi;
        do_reset();
        for (int n = 0; n < 600; n++) begin
            pv = ($urandom_range(0, 3) != 0);
            pt = $urandom_range(0, 1);
            pi = $urandom_range(0, 15);
            rv = $urandom_range(0, 1);
            if (q.size() != 0 && $urandom_range(0, 5) != 0) rt = q[0].taken;
            else rt = $urandom_range(0, 1);
            step(pv, pi, pt, rv, rt);
            checks++;
            if (obs_ready_pre !== exp_ready_pre || observed() !== expected()) begin
                failures++;
                $display("[TB] FAIL random_%0d: got rdy=%b %h expected rdy=%b %h",
                         n, obs_ready_pre, observed(), exp_ready_pre, expected());
            end
        end
    endtask

`ifdef BHR_STATS_EN
    task automatic test_stats();
        do_reset();
        step(1, 1, 1, 0, 0);
        step(1, 2, 1, 0, 0);
        step(1, 3, 1, 0, 0);
        step(0, 0, 0, 1, 1);
        step(0, 0, 0, 1, 1);
        step(0, 0, 0, 1, 0);
        checks++;
        if (stat_resolved !== 16'd3 || stat_mispred !== 16'd1) begin
            failures++;
            $display("[TB] FAIL stats: got %0d/%0d expected 3/1", stat_resolved, stat_mispred);
        end
        step(0, 0, 0, 1, 1);
        checks++;
        if (stat_resolved !== 16'(m_res) || stat_mispred !== 16'(m_mis_cnt)) begin
            failures++;
            $display("[TB] FAIL stats_empty: got %0d/%0d expected %0d/%0d",
                     stat_resolved, stat_mispred, m_res, m_mis_cnt);
        end
    endtask
`endif

    initial begin
        model_clear();
        test_reset();
        test_basic();
        test_mispredict();
        test_full();
        test_accept_mispredict();
        test_back_to_back();
        test_random();
`ifdef BHR_STATS_EN
        test_stats();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
